// File: rtl/bean_pkg.sv
// rtl/bean_pkg.sv - shared sprite constants and FSM state type for the bean field
package bean_pkg;

  localparam int BEAN_SZ = 10;

  // Bit 0 is the leftmost sprite column.
  localparam logic [BEAN_SZ-1:0] BEAN_ROWS [BEAN_SZ] = '{
    10'h000, 10'h000, 10'h030, 10'h078, 10'h0FC,
    10'h0FC, 10'h078, 10'h030, 10'h000, 10'h000
  };

  typedef enum logic [1:0] {INIT, RUN, DONE} bean_state_e;

endpackage

// File: rtl/bean_cell_map.sv
// rtl/bean_cell_map.sv - maps a pixel to its grid cell index and in-cell offset
module bean_cell_map #(
  parameter int COLS = 16,
  parameter int ROWS = 12,
  parameter int CELL = 16,
  parameter int X0   = 0,
  parameter int Y0   = 0,
  parameter int AW   = 8
) (
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  output logic          in_field,
  output logic [AW-1:0] idx,
  output logic [9:0]    ox,
  output logic [9:0]    oy
);

  localparam int         SH   = $clog2(CELL);
  localparam logic [9:0] MASK = 10'(CELL - 1);

  logic [9:0] dx, dy, col, row;

  // CELL is a power of two, so division and modulo reduce to shift and mask.
  assign dx  = x - 10'(X0);
  assign dy  = y - 10'(Y0);
  assign col = dx >> SH;
  assign row = dy >> SH;
  assign ox  = dx & MASK;
  assign oy  = dy & MASK;

  assign in_field = (int'(x) >= X0) && (int'(x) < X0 + COLS * CELL) &&
                    (int'(y) >= Y0) && (int'(y) < Y0 + ROWS * CELL);

  assign idx = AW'(int'(row) * COLS + int'(col));

endmodule

// File: rtl/bean_sprite_rom.sv
// rtl/bean_sprite_rom.sv - combinational bean sprite row lookup
module bean_sprite_rom
  import bean_pkg::*;
(
  input  logic [3:0]         row_addr,
  output logic [BEAN_SZ-1:0] row_bits
);

  always_comb begin
    row_bits = '0;
    if (row_addr < 4'(BEAN_SZ)) row_bits = BEAN_ROWS[row_addr];
  end

endmodule

// File: rtl/bean_field.sv
// rtl/bean_field.sv - pellet presence grid, bean sprite render, eat detection and scoring
module bean_field
  import bean_pkg::*;
#(
  parameter int COLS   = 16,
  parameter int ROWS   = 12,
  parameter int CELL   = 16,
  parameter int X0     = 0,
  parameter int Y0     = 0,
  parameter int POINTS = 10
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [9:0]                        p_x,
  input  logic [9:0]                        p_y,
  input  logic [9:0]                        pac_x,
  input  logic [9:0]                        pac_y,
  input  logic                              eat_en,
  input  logic                              restart,
  output logic                              bean_on,
  output logic                              eat_pulse,
  output logic [15:0]                       score,
  output logic [$clog2(ROWS*COLS+1)-1:0]    beans_left,
  output logic                              all_eaten,
  output logic                              init_busy
);

  localparam int          NB  = ROWS * COLS;
  localparam int          AW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int          BW  = $clog2(NB + 1);
  localparam int          OFF = (CELL - BEAN_SZ) / 2;
  localparam logic [16:0] PTS = (POINTS > 65535) ? 17'h0FFFF : 17'(POINTS);

  bean_state_e   state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [NB-1:0] bits_q, bits_d;
  logic [15:0]   score_q, score_d;
  logic [BW-1:0] left_q, left_d;
  logic          eat_q, eat_d;
  logic          bean_q, bean_d;

  logic          pix_in, pac_in;
  logic [AW-1:0] pix_idx, pac_idx;
  logic [9:0]    pix_ox, pix_oy, unused_pac_ox, unused_pac_oy;

  bean_cell_map #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .X0(X0), .Y0(Y0), .AW(AW)
  ) u_pix_map (
    .x(p_x), .y(p_y), .in_field(pix_in), .idx(pix_idx), .ox(pix_ox), .oy(pix_oy)
  );

  bean_cell_map #(
    .COLS(COLS), .ROWS(ROWS), .CELL(CELL), .X0(X0), .Y0(Y0), .AW(AW)
  ) u_pac_map (
    .x(pac_x), .y(pac_y), .in_field(pac_in), .idx(pac_idx),
    .ox(unused_pac_ox), .oy(unused_pac_oy)
  );

  logic [9:0]         sx, sy;
  logic               in_win;
  logic [BEAN_SZ-1:0] sprite_row;
  logic [16:0]        score_sum;

  // Sprite-local coordinates; the window test uses the full width so underflow reads as outside.
  assign sx     = pix_ox - 10'(OFF);
  assign sy     = pix_oy - 10'(OFF);
  assign in_win = (pix_ox >= 10'(OFF)) && (sx < 10'(BEAN_SZ)) &&
                  (pix_oy >= 10'(OFF)) && (sy < 10'(BEAN_SZ));

  bean_sprite_rom u_rom (
    .row_addr(sy[3:0]),
    .row_bits(sprite_row)
  );

  assign score_sum = {1'b0, score_q} + PTS;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    bits_d  = bits_q;
    score_d = score_q;
    left_d  = left_q;
    eat_d   = 1'b0;
    bean_d  = pix_in && in_win && (state_q != INIT) &&
              bits_q[pix_idx] && sprite_row[sx[3:0]];

    if (restart) begin
      state_d = INIT;
      addr_d  = '0;
      score_d = '0;
      left_d  = '0;
    end else begin
      case (state_q)
        INIT: begin
          bits_d[addr_q] = 1'b1;
          if (addr_q == AW'(NB - 1)) begin
            state_d = RUN;
            left_d  = BW'(NB);
          end else begin
            addr_d = addr_q + AW'(1);
          end
        end
        RUN: begin
          if (eat_en && pac_in && bits_q[pac_idx]) begin
            bits_d[pac_idx] = 1'b0;
            score_d         = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            left_d          = left_q - BW'(1);
            eat_d           = 1'b1;
            if (left_q == BW'(1)) state_d = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= INIT;
      addr_q  <= '0;
      bits_q  <= '0;
      score_q <= '0;
      left_q  <= '0;
      eat_q   <= 1'b0;
      bean_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bits_q  <= bits_d;
      score_q <= score_d;
      left_q  <= left_d;
      eat_q   <= eat_d;
      bean_q  <= bean_d;
    end
  end

  assign bean_on    = bean_q;
  assign eat_pulse  = eat_q;
  assign score      = score_q;
  assign beans_left = left_q;
  assign all_eaten  = (state_q == DONE);
  assign init_busy  = (state_q == INIT);

endmodule

// File: tb/tb_bean_field.sv
// tb/tb_bean_field.sv - scoreboard bench for bean_field (default grid and a 2x1 saturating grid)
module tb_bean_field;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic [9:0]  a_px, a_py, a_pacx, a_pacy;
  logic        a_eat, a_restart;
  logic        a_bean, a_pulse, a_all, a_busy;
  logic [15:0] a_score;
  logic [7:0]  a_left;

  logic [9:0]  b_px, b_py, b_pacx, b_pacy;
  logic        b_eat, b_restart;
  logic        b_bean, b_pulse, b_all, b_busy;
  logic [15:0] b_score;
  logic [1:0]  b_left;

  bean_field dut_a (
    .clk(clk), .rst_n(rst_n), .p_x(a_px), .p_y(a_py), .pac_x(a_pacx), .pac_y(a_pacy),
    .eat_en(a_eat), .restart(a_restart), .bean_on(a_bean), .eat_pulse(a_pulse),
    .score(a_score), .beans_left(a_left), .all_eaten(a_all), .init_busy(a_busy)
  );

  bean_field #(.COLS(2), .ROWS(1), .POINTS(40000)) dut_b (
    .clk(clk), .rst_n(rst_n), .p_x(b_px), .p_y(b_py), .pac_x(b_pacx), .pac_y(b_pacy),
    .eat_en(b_eat), .restart(b_restart), .bean_on(b_bean), .eat_pulse(b_pulse),
    .score(b_score), .beans_left(b_left), .all_eaten(b_all), .init_busy(b_busy)
  );

  localparam int S_BEAN = 0, S_EAT = 1, S_SCORE = 2, S_LEFT = 3, S_ALL = 4, S_BUSY = 5;

  typedef struct {
    string tag;
    bit    on_b;
    int    sig;
    int    exp;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int observe(input bit on_b, input int sig);
    if (!on_b) begin
      case (sig)
        S_BEAN:  return int'(a_bean);
        S_EAT:   return int'(a_pulse);
        S_SCORE: return int'(a_score);
        S_LEFT:  return int'(a_left);
        S_ALL:   return int'(a_all);
        default: return int'(a_busy);
      endcase
    end else begin
      case (sig)
        S_BEAN:  return int'(b_bean);
        S_EAT:   return int'(b_pulse);
        S_SCORE: return int'(b_score);
        S_LEFT:  return int'(b_left);
        S_ALL:   return int'(b_all);
        default: return int'(b_busy);
      endcase
    end
  endfunction

  task automatic push_exp(input string tag, input bit on_b, input int sig, input int exp);
    exp_t e;
    e.tag  = tag;
    e.on_b = on_b;
    e.sig  = sig;
    e.exp  = exp;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq(e.tag, observe(e.on_b, e.sig), e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic count_init(input bit on_b, input int expn, input string tag);
    int n;
    n = 0;
    while (observe(on_b, S_BUSY) == 1 && n < 1000) begin
      step();
      n++;
    end
    check_eq(tag, n, expn);
  endtask

  initial begin
    rst_n = 1'b0;
    a_px = '0; a_py = '0; a_pacx = '0; a_pacy = '0; a_eat = 1'b0; a_restart = 1'b0;
    b_px = '0; b_py = '0; b_pacx = '0; b_pacy = '0; b_eat = 1'b0; b_restart = 1'b0;
    repeat (3) @(negedge clk);

    push_exp("rst_busy", 0, S_BUSY, 1);
    push_exp("rst_bean", 0, S_BEAN, 0);
    push_exp("rst_pulse", 0, S_EAT, 0);
    push_exp("rst_score", 0, S_SCORE, 0);
    push_exp("rst_left", 0, S_LEFT, 0);
    push_exp("rst_all", 0, S_ALL, 0);
    drain();

    rst_n = 1'b1;
    count_init(0, 192, "init_len_a");
    push_exp("init_left_a", 0, S_LEFT, 192);
    push_exp("init_score_a", 0, S_SCORE, 0);
    push_exp("init_all_a", 0, S_ALL, 0);
    push_exp("init_left_b", 1, S_LEFT, 2);
    drain();

    a_px = 10'd8;   a_py = 10'd7;   push_exp("bean_8_7", 0, S_BEAN, 1);     step();
    a_px = 10'd3;   a_py = 10'd3;   push_exp("bean_3_3", 0, S_BEAN, 0);     step();
    a_px = 10'd300; a_py = 10'd300; push_exp("bean_out", 0, S_BEAN, 0);     step();
    a_px = 10'd8;   a_py = 10'd17;  push_exp("bean_8_17", 0, S_BEAN, 0);    step();
    a_px = 10'd24;  a_py = 10'd7;   push_exp("bean_24_7_pre", 0, S_BEAN, 1); step();

    a_pacx = 10'd24; a_pacy = 10'd8; a_eat = 1'b1;
    push_exp("eat1_pulse", 0, S_EAT, 1);
    push_exp("eat1_score", 0, S_SCORE, 10);
    push_exp("eat1_left", 0, S_LEFT, 191);
    push_exp("render_old_bit", 0, S_BEAN, 1);
    step();
    a_eat = 1'b0;
    push_exp("render_new_bit", 0, S_BEAN, 0);
    push_exp("pulse_one_cycle", 0, S_EAT, 0);
    step();
    a_eat = 1'b1;
    push_exp("reeat_pulse", 0, S_EAT, 0);
    push_exp("reeat_score", 0, S_SCORE, 10);
    push_exp("reeat_left", 0, S_LEFT, 191);
    step();

    a_pacx = 10'd40;
    push_exp("b2b1_pulse", 0, S_EAT, 1);
    push_exp("b2b1_score", 0, S_SCORE, 20);
    push_exp("b2b1_left", 0, S_LEFT, 190);
    step();
    push_exp("b2b2_pulse", 0, S_EAT, 0);
    push_exp("b2b2_score", 0, S_SCORE, 20);
    push_exp("b2b2_left", 0, S_LEFT, 190);
    step();

    a_pacx = 10'd300; a_pacy = 10'd300;
    push_exp("pac_out_pulse", 0, S_EAT, 0);
    push_exp("pac_out_score", 0, S_SCORE, 20);
    step();

    a_pacx = 10'd8; a_pacy = 10'd8; a_restart = 1'b1;
    push_exp("rs_eat_pulse", 0, S_EAT, 0);
    push_exp("rs_eat_score", 0, S_SCORE, 0);
    push_exp("rs_eat_busy", 0, S_BUSY, 1);
    push_exp("rs_eat_left", 0, S_LEFT, 0);
    push_exp("rs_eat_all", 0, S_ALL, 0);
    step();
    a_restart = 1'b0;
    push_exp("init_eat_pulse", 0, S_EAT, 0);
    push_exp("init_eat_score", 0, S_SCORE, 0);
    step();
    a_eat = 1'b0;
    repeat (40) step();
    push_exp("mid_init_busy", 0, S_BUSY, 1);
    push_exp("mid_init_left", 0, S_LEFT, 0);
    drain();
    a_restart = 1'b1;
    push_exp("rs_mid_init_busy", 0, S_BUSY, 1);
    step();
    a_restart = 1'b0;
    count_init(0, 192, "init_len_restart");
    a_px = 10'd24; a_py = 10'd7;
    push_exp("refill_left", 0, S_LEFT, 192);
    push_exp("refill_score", 0, S_SCORE, 0);
    push_exp("refill_bean", 0, S_BEAN, 1);
    step();

    b_pacx = 10'd40; b_pacy = 10'd8; b_eat = 1'b1;
    push_exp("b_out_pulse", 1, S_EAT, 0);
    push_exp("b_out_left", 1, S_LEFT, 2);
    step();
    b_pacx = 10'd8;
    push_exp("b_eat1_pulse", 1, S_EAT, 1);
    push_exp("b_eat1_score", 1, S_SCORE, 40000);
    push_exp("b_eat1_left", 1, S_LEFT, 1);
    push_exp("b_eat1_all", 1, S_ALL, 0);
    step();
    b_pacx = 10'd24;
    push_exp("b_eat2_pulse", 1, S_EAT, 1);
    push_exp("b_eat2_score_sat", 1, S_SCORE, 65535);
    push_exp("b_eat2_left", 1, S_LEFT, 0);
    push_exp("b_eat2_all", 1, S_ALL, 1);
    step();
    b_px = 10'd8; b_py = 10'd7;
    push_exp("b_done_pulse", 1, S_EAT, 0);
    push_exp("b_done_score", 1, S_SCORE, 65535);
    push_exp("b_done_all", 1, S_ALL, 1);
    push_exp("b_done_bean", 1, S_BEAN, 0);
    step();
    b_eat = 1'b0; b_restart = 1'b1;
    push_exp("b_rs_busy", 1, S_BUSY, 1);
    push_exp("b_rs_score", 1, S_SCORE, 0);
    push_exp("b_rs_all", 1, S_ALL, 0);
    step();
    b_restart = 1'b0;
    count_init(1, 2, "init_len_b");
    push_exp("b_refill_left", 1, S_LEFT, 2);
    push_exp("b_refill_bean", 1, S_BEAN, 1);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
